seg7_scan_decoder: RTL and testbench

- Receive-side counterpart of the BCD-to-7-segment encoder: recovers BCD digits from a time-multiplexed 7-segment scan bus (digit-enable plus segment lines).
- Used for loopback checking of display drivers and for reading scanned displays back into the datapath.
- Per-digit capture is gated by a stability filter so scan transitions and ghosting are never latched.
- Produces per-digit BCD, valid flags, a frame-complete strobe and an illegal-pattern error strobe.

---
 rtl/seg7_scan_decoder.sv | 179 +++++++++++++++++
 tb/tb_seg7_scan_decoder.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers BCD digits from a multiplexed 7-segment scan bus
// Optional build macro SEG7_ACTIVE_LOW_EN: inverts seg_in/an_in ahead of the input register
// so common-anode (active-low) scan buses decode with the same tables and timing.
module seg7_scan_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] bcd_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    err,
  output logic [2:0]              err_digit
);

  localparam logic [7:0] STABLE_C  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_M1 = 8'(STABLE_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  logic [NUM_DIGITS-1:0]   an_eff;
  logic [6:0]              seg_eff;

  state_t                  state_q, state_d;
  logic [NUM_DIGITS-1:0]   s_an_q;
  logic [6:0]              s_seg_q;
  logic [7:0]              cnt_q, cnt_d;
  logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_q, frame_d;
  logic                    err_q, err_d;
  logic [2:0]              err_digit_q, err_digit_d;

  logic                    chg;
  logic                    new_onehot;
  logic                    capture;
  logic                    legal;
  logic [3:0]              value;
  int                      idx;
  logic [NUM_DIGITS-1:0]   seen_nxt;

`ifdef SEG7_ACTIVE_LOW_EN
  assign an_eff  = ~an_in;
  assign seg_eff = ~seg_in;
`else
  assign an_eff  = an_in;
  assign seg_eff = seg_in;
`endif

  // Sample change detection and one-hot qualification of the incoming enable
  assign chg        = ({an_eff, seg_eff} != {s_an_q, s_seg_q});
  assign new_onehot = $onehot(an_eff);

  // Segment pattern to BCD lookup on the held sample; anything unlisted is illegal
  always_comb begin
    legal = 1'b1;
    value = 4'hF;
    case (s_seg_q)
      7'b1111110: value = 4'd0;
      7'b0110000: value = 4'd1;
      7'b1101101: value = 4'd2;
      7'b1111001: value = 4'd3;
      7'b0110011: value = 4'd4;
      7'b1011011: value = 4'd5;
      7'b1011111: value = 4'd6;
      7'b1110000: value = 4'd7;
      7'b1111111: value = 4'd8;
      7'b1111011: value = 4'd9;
      default:    legal = 1'b0;
    endcase
  end

  // Index of the enabled digit in the held sample
  always_comb begin
    idx = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (s_an_q[i]) idx = i;
    end
  end

  // Next-state: stability counting, capture decision and digit/flag updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bcd_d       = bcd_q;
    valid_d     = valid_q;
    seen_d      = seen_q;
    frame_d     = 1'b0;
    err_d       = 1'b0;
    err_digit_d = err_digit_q;
    capture     = 1'b0;
    seen_nxt    = seen_q | s_an_q;

    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        if (new_onehot) state_d = SETTLE;
      end
      SETTLE: begin
        if (chg) begin
          cnt_d   = 8'd0;
          state_d = new_onehot ? SETTLE : IDLE;
        end else if (cnt_q == STABLE_M1) begin
          cnt_d   = STABLE_C;
          capture = 1'b1;
          state_d = HELD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HELD: begin
        if (chg) begin
          cnt_d   = 8'd0;
          state_d = new_onehot ? SETTLE : IDLE;
        end
      end
      default: begin
        cnt_d   = 8'd0;
        state_d = IDLE;
      end
    endcase

    if (capture) begin
      if (legal) begin
        bcd_d[4*idx +: 4] = value;
        valid_d[idx]      = 1'b1;
        if (&seen_nxt) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end else begin
          seen_d = seen_nxt;
        end
      end else begin
        bcd_d[4*idx +: 4] = 4'hF;
        valid_d[idx]      = 1'b0;
        err_d             = 1'b1;
        err_digit_d       = 3'(idx);
      end
    end
  end

  // Input register plus all state and output registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      s_an_q      <= '0;
      s_seg_q     <= '0;
      cnt_q       <= '0;
      bcd_q       <= '0;
      valid_q     <= '0;
      seen_q      <= '0;
      frame_q     <= 1'b0;
      err_q       <= 1'b0;
      err_digit_q <= '0;
    end else begin
      state_q     <= state_d;
      s_an_q      <= an_eff;
      s_seg_q     <= seg_eff;
      cnt_q       <= cnt_d;
      bcd_q       <= bcd_d;
      valid_q     <= valid_d;
      seen_q      <= seen_d;
      frame_q     <= frame_d;
      err_q       <= err_d;
      err_digit_q <= err_digit_d;
    end
  end

  assign bcd_out     = bcd_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_q;
  assign err         = err_q;
  assign err_digit   = err_digit_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - randomized and directed bench for seg7_scan_decoder
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int ST = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [6:0]      seg_in;
  logic [ND-1:0]   an_in;
  logic [4*ND-1:0] bcd_out;
  logic [ND-1:0]   digit_valid;
  logic            frame_done;
  logic            err;
  logic [2:0]      err_digit;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(ST)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .bcd_out(bcd_out), .digit_valid(digit_valid), .frame_done(frame_done),
    .err(err), .err_digit(err_digit)
  );

  always #5 clk = ~clk;

  logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                               7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Logical (active-high) view of what the bench is presenting
  logic [ND-1:0] l_an  = '0;
  logic [6:0]    l_seg = '0;

  // Reference model state
  logic [ND-1:0]   m_an = '0;
  logic [6:0]      m_seg = '0;
  int              m_run = 0;
  logic [4*ND-1:0] m_bcd = '0;
  logic [ND-1:0]   m_valid = '0;
  logic [ND-1:0]   m_seen = '0;
  logic            m_fd = 1'b0;
  logic            m_err = 1'b0;
  logic [2:0]      m_ed = '0;

  int cyc = 0;
  int fd_cnt = 0;
  int err_cnt = 0;
  int fd_cyc = -1;

  // Model: a capture happens when a one-hot sample has been seen unchanged for exactly ST edges
  // after the edge that first loaded it; the compare follows 1ns later.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_an = '0; m_seg = '0; m_run = 0; m_bcd = '0; m_valid = '0;
      m_seen = '0; m_fd = 1'b0; m_err = 1'b0; m_ed = '0;
    end else begin
      int d;
      int v;
      cyc++;
      m_fd  = 1'b0;
      m_err = 1'b0;
      if (l_an != m_an || l_seg != m_seg) begin
        m_an = l_an; m_seg = l_seg; m_run = 0;
      end else begin
        m_run++;
      end
      if (m_run == ST && $onehot(m_an)) begin
        d = 0;
        for (int i = 0; i < ND; i++) if (m_an[i]) d = i;
        v = -1;
        for (int k = 0; k < 10; k++) if (seg_tab[k] == m_seg) v = k;
        if (v >= 0) begin
          m_bcd[4*d +: 4] = 4'(v);
          m_valid[d] = 1'b1;
          m_seen[d] = 1'b1;
          if (m_seen == {ND{1'b1}}) begin
            m_fd = 1'b1;
            m_seen = '0;
          end
        end else begin
          m_bcd[4*d +: 4] = 4'hF;
          m_valid[d] = 1'b0;
          m_err = 1'b1;
          m_ed = 3'(d);
        end
      end
    end
    #1;
    check("bcd_out", 32'(bcd_out), 32'(m_bcd));
    check("digit_valid", 32'(digit_valid), 32'(m_valid));
    check("frame_done", 32'(frame_done), 32'(m_fd));
    check("err", 32'(err), 32'(m_err));
    check("err_digit", 32'(err_digit), 32'(m_ed));
    if (frame_done === 1'b1) begin fd_cnt++; fd_cyc = cyc; end
    if (err === 1'b1) err_cnt++;
  end

  task automatic drive(input logic [ND-1:0] an, input logic [6:0] seg, input int cycles);
    l_an  = an;
    l_seg = seg;
`ifdef SEG7_ACTIVE_LOW_EN
    an_in  = ~an;
    seg_in = ~seg;
`else
    an_in  = an;
    seg_in = seg;
`endif
    repeat (cycles) @(negedge clk);
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_bcd", 32'(bcd_out), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_pulses", {29'd0, frame_done, err, 1'b0}, 32'h0);
    check("rst_err_digit", 32'(err_digit), 32'h0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int n;
    int f0;
    int e0;
    logic [4*ND-1:0] snap;

    rst = 1'b1;
    drive('0, '0, 2);
    rst = 1'b0;
    check("post_reset_bcd", 32'(bcd_out), 32'h0);
    check("post_reset_valid", 32'(digit_valid), 32'h0);

    // Glitch rejection and capture latency pin
    drive(4'b0001, 7'b0110000, 3);
    drive(4'b0001, 7'b0110001, 1);
    drive(4'b0001, 7'b0110000, ST);
    check("glitch_no_early", 32'(digit_valid[0]), 32'h0);
    drive(4'b0001, 7'b0110000, 1);
    check("glitch_valid0", 32'(digit_valid[0]), 32'h1);
    check("glitch_digit0", 32'(bcd_out[3:0]), 32'h1);
    check("glitch_no_err", 32'(err_cnt), 32'h0);

    // Four-digit scan
    f0 = fd_cnt;
    drive(4'b0001, 7'b1111001, 6);
    drive(4'b0010, 7'b0110011, 6);
    drive(4'b0100, 7'b1111111, 6);
    n = cyc;
    drive(4'b1000, 7'b1111110, 6);
    check("scan_bcd", 32'(bcd_out), 32'h0843);
    check("scan_valid", 32'(digit_valid), 32'hF);
    check("scan_frame_cnt", 32'(fd_cnt - f0), 32'h1);
    check("scan_frame_edge", 32'(fd_cyc), 32'(n + 1 + ST));

    // Illegal pattern
    f0 = fd_cnt;
    e0 = err_cnt;
    drive(4'b0010, 7'b1000000, 5);
    check("illegal_err_cnt", 32'(err_cnt - e0), 32'h1);
    check("illegal_err_digit", 32'(err_digit), 32'h1);
    check("illegal_digit1", 32'(bcd_out[7:4]), 32'hF);
    check("illegal_valid1", 32'(digit_valid[1]), 32'h0);
    check("illegal_no_frame", 32'(fd_cnt - f0), 32'h0);

    // Non-one-hot enables
    snap = bcd_out;
    f0 = fd_cnt;
    e0 = err_cnt;
    drive(4'b0011, 7'b1111110, 10);
    drive(4'b0000, 7'b0110000, 10);
    check("nonhot_bcd", 32'(bcd_out), 32'(snap));
    check("nonhot_pulses", 32'((fd_cnt - f0) + (err_cnt - e0)), 32'h0);

    // Digit 9 (inverted on the wire in the active-low build)
    drive(4'b0001, 7'b1111011, 5);
    check("nine_digit0", 32'(bcd_out[3:0]), 32'h9);
    check("nine_valid0", 32'(digit_valid[0]), 32'h1);

    async_reset();

    // Randomized scanning with occasional glitches, blanks and resets
    for (int t = 0; t < 400; t++) begin
      logic [ND-1:0] an;
      logic [6:0] seg;
      int r;
      r = $urandom_range(0, 99);
      if (r < 70)      an = ND'(1) << $urandom_range(0, ND - 1);
      else if (r < 85) an = '0;
      else             an = ND'($urandom);
      if ($urandom_range(0, 3) != 0) seg = seg_tab[$urandom_range(0, 9)];
      else                           seg = 7'($urandom);
      drive(an, seg, $urandom_range(1, 8));
      if ($urandom_range(0, 59) == 0) async_reset();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
